// File: rtl/ysyx_25030093_ifu_idu_buffer.sv
// Fetch-to-decode decoupling FIFO with valid/ready on both sides, per-entry
// opcode-class pre-decode, and a saturating counter of beats dropped on redirect.
module ysyx_25030093_ifu_idu_buffer #(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [2:0]        out_cls,
    input  logic              flush,
    output logic [7:0]        flush_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BRANCH  = 3'd3;
    localparam logic [2:0] CLS_JAL     = 3'd4;
    localparam logic [2:0] CLS_JALR    = 3'd5;
    localparam logic [2:0] CLS_SYSTEM  = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    function automatic logic [2:0] predecode(input logic [6:0] opc);
        logic [2:0] cls;
        cls = CLS_ILLEGAL;
        if (opc[1:0] == 2'b11) begin
            case (opc)
                OPC_OP, OPC_OP_IMM, OPC_LUI,
                OPC_AUIPC, OPC_FENCE: cls = CLS_ALU;
                OPC_LOAD:             cls = CLS_LOAD;
                OPC_STORE:            cls = CLS_STORE;
                OPC_BRANCH:           cls = CLS_BRANCH;
                OPC_JAL:              cls = CLS_JAL;
                OPC_JALR:             cls = CLS_JALR;
                OPC_SYSTEM:           cls = CLS_SYSTEM;
                default:              cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    // Storage is left unreset: head outputs are masked whenever the buffer is empty.
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [2:0]        cls_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic [7:0]       drop_reg,   drop_next;
    logic [8:0]       drop_sum;
    logic             non_empty;
    logic             push;
    logic             pop;

    assign non_empty = (count_reg != '0);
    assign in_ready  = rst & (count_reg < CNT_W'(DEPTH)) & ~flush;
    assign out_valid = non_empty & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_pc     = non_empty ? pc_mem[rd_ptr_reg]   : '0;
    assign out_inst   = non_empty ? inst_mem[rd_ptr_reg] : '0;
    assign out_cls    = non_empty ? cls_mem[rd_ptr_reg]  : '0;
    assign flush_drop = drop_reg;

    assign drop_sum = {1'b0, drop_reg} + 9'(count_reg);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        drop_next   = drop_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            drop_next   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            drop_reg   <= drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= in_pc;
            inst_mem[wr_ptr_reg] <= in_inst;
            cls_mem[wr_ptr_reg]  <= predecode(in_inst[6:0]);
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_ifu_idu_buffer.sv
// Directed bench for the fetch/decode buffer: handshake, ordering, pre-decode,
// flush accounting with saturation, and asynchronous reset.
module tb_ysyx_25030093_ifu_idu_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_cls;
    logic        flush;
    logic [7:0]  flush_drop;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_25030093_ifu_idu_buffer #(.DEPTH(2), .PC_W(32), .INST_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_cls    (out_cls),
        .flush      (flush),
        .flush_drop (flush_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let them settle.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    initial begin
        logic [8:0] exp_drop;
        rst = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;

        drive(1, 32'h1234, 32'h13, 1, 0);
        drive(1, 32'h1234, 32'h13, 1, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_cls", out_cls, 0);
        chk("rst_flush_drop", flush_drop, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Single beat, one-cycle latency
        drive(1, 32'h8000_0000, 32'h0000_0413, 1, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_no_bypass", out_valid, 0);
        drive(0, 0, 0, 1, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_pc", out_pc, 32'h8000_0000);
        chk("t1_out_inst", out_inst, 32'h0000_0413);
        chk("t1_out_cls", out_cls, 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_empty", out_valid, 0);
        chk("t1_empty_pc", out_pc, 0);

        // Fill to full with decode stalled
        drive(1, 32'h100, 32'h0000_2083, 0, 0);
        drive(1, 32'h104, 32'h0011_2023, 0, 0);
        chk("t2_second_ready", in_ready, 1);
        drive(0, 0, 0, 0, 0);
        chk("t2_full_in_ready", in_ready, 0);
        chk("t2_head_cls", out_cls, 1);
        chk("t2_head_pc", out_pc, 32'h100);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("t2_after_pop_cls", out_cls, 2);
        chk("t2_after_pop_pc", out_pc, 32'h104);
        chk("t2_after_pop_ready", in_ready, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("t2_drained", out_valid, 0);

        // Steady push+pop at count=1
        drive(1, 32'h200, 32'h13, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h204 + 32'(4 * i), 32'h13, 1, 0);
            chk($sformatf("t3_pc_%0d", i), out_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("t3_valid_%0d", i), out_valid, 1);
            chk($sformatf("t3_ready_%0d", i), in_ready, 1);
        end
        drive(0, 0, 0, 1, 0);
        chk("t3_last_pc", out_pc, 32'h228);
        drive(0, 0, 0, 0, 0);
        chk("t3_drained", out_valid, 0);

        // Flush accounting with saturation
        for (int k = 1; k <= 130; k++) begin
            drive(1, 32'h400, 32'h13, 0, 0);
            drive(1, 32'h404, 32'h13, 0, 0);
            drive(0, 0, 0, 1, 1);
            if (k == 1) begin
                chk("t4_flush_out_valid", out_valid, 0);
                chk("t4_flush_in_ready", in_ready, 0);
            end
            drive(0, 0, 0, 0, 0);
            exp_drop = (2 * k > 255) ? 9'd255 : 9'(2 * k);
            chk($sformatf("t4_drop_%0d", k), flush_drop, exp_drop);
            if (k == 1) begin
                chk("t4_empty_after", out_valid, 0);
                chk("t4_ready_after", in_ready, 1);
            end
        end

        // Pre-decode classes through a streaming path
        drive(1, 32'h500, 32'h0000_006F, 1, 0);
        drive(1, 32'h504, 32'h0000_8067, 1, 0);
        chk("t5_cls_jal", out_cls, 4);
        drive(1, 32'h508, 32'h0000_0073, 1, 0);
        chk("t5_cls_jalr", out_cls, 5);
        drive(1, 32'h50C, 32'h0000_0000, 1, 0);
        chk("t5_cls_system", out_cls, 6);
        drive(0, 0, 0, 1, 0);
        chk("t5_cls_illegal", out_cls, 7);
        drive(0, 0, 0, 0, 0);
        chk("t5_drained", out_valid, 0);

        // Asynchronous reset mid-cycle
        drive(1, 32'h600, 32'h13, 0, 0);
        drive(1, 32'h604, 32'h13, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t6_pre_valid", out_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_ready", in_ready, 0);
        chk("t6_async_drop", flush_drop, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'h700, 32'h0000_2083, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t6_first_valid", out_valid, 1);
        chk("t6_first_pc", out_pc, 32'h700);
        chk("t6_first_cls", out_cls, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
